// File: rtl/uart_tx_controller.sv
// UART transmit frame sequencer.
// Latches a parallel word on request, steps start / data / parity / stop,
// and drives the external serializer's enable and parallel-data inputs.
//
// state    | meaning
// ---------+----------------------------------------------------------
// S_IDLE   | line held high, waiting for a data-valid request
// S_START  | start bit (line low), serializer held
// S_DATA   | serializer running, line follows serializer output
// S_PARITY | latched parity bit on the line (only when parity enabled)
// S_STOP   | stop bit (line high), done pulse for this cycle only
module uart_tx_controller #(
  parameter int WIDTH = 3
) (
  input  logic                UART_TX_CLK,
  input  logic                UART_TX_RST_ASYN,
  input  logic [2**WIDTH-1:0] UART_TX_P_DATA,
  input  logic                UART_TX_Data_Valid,
  input  logic                UART_TX_PAR_EN,
  input  logic                UART_TX_PAR_TYP,
  input  logic                UART_TX_Ser_Done,
  input  logic                UART_TX_Ser_Data,
  output logic                UART_TX_Ser_En,
  output logic [2**WIDTH-1:0] UART_TX_Ser_PData,
  output logic                UART_TX_OUT,
  output logic                UART_TX_Busy,
  output logic                UART_TX_Done
);

  localparam int DW = 2**WIDTH;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [DW-1:0]   data_q;
  logic            par_en_q;
  logic            parity_q;
  logic            accept;

  // A request is only honoured while the line is idle; anything else is ignored.
  assign accept = (state == S_IDLE) && UART_TX_Data_Valid;

  // State register.
  always_ff @(posedge UART_TX_CLK or negedge UART_TX_RST_ASYN) begin
    if (!UART_TX_RST_ASYN) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Word, parity-enable and parity bit are captured together at accept so
  // later input changes cannot disturb the frame in flight.
  always_ff @(posedge UART_TX_CLK or negedge UART_TX_RST_ASYN) begin
    if (!UART_TX_RST_ASYN) begin
      data_q   <= '0;
      par_en_q <= 1'b0;
      parity_q <= 1'b0;
    end else if (accept) begin
      data_q   <= UART_TX_P_DATA;
      par_en_q <= UART_TX_PAR_EN;
      parity_q <= (^UART_TX_P_DATA) ^ UART_TX_PAR_TYP;
    end
  end

  // Next-state decode; serializer done only matters while in DATA.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (UART_TX_Data_Valid) begin
          state_nxt = S_START;
        end
      end
      S_START: begin
        state_nxt = S_DATA;
      end
      S_DATA: begin
        if (UART_TX_Ser_Done) begin
          state_nxt = par_en_q ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        state_nxt = S_STOP;
      end
      S_STOP: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Output decode from the state register only (plus serial data in DATA).
  always_comb begin
    UART_TX_OUT    = 1'b1;
    UART_TX_Ser_En = 1'b0;
    UART_TX_Done   = 1'b0;
    unique case (state)
      S_IDLE: begin
        UART_TX_OUT = 1'b1;
      end
      S_START: begin
        UART_TX_OUT = 1'b0;
      end
      S_DATA: begin
        UART_TX_OUT    = UART_TX_Ser_Data;
        UART_TX_Ser_En = 1'b1;
      end
      S_PARITY: begin
        UART_TX_OUT = parity_q;
      end
      S_STOP: begin
        UART_TX_OUT  = 1'b1;
        UART_TX_Done = 1'b1;
      end
      default: begin
        UART_TX_OUT = 1'b1;
      end
    endcase
  end

  assign UART_TX_Busy      = (state != S_IDLE);
  assign UART_TX_Ser_PData = data_q;

endmodule

// File: tb/tb_uart_tx_controller.sv
// Directed bench for uart_tx_controller with a behavioural serializer.
module tb_uart_tx_controller;

  logic       clk;
  logic       rst_n;
  logic [7:0] p_data;
  logic       data_valid;
  logic       par_en;
  logic       par_typ;
  logic       ser_done;
  logic       ser_data;
  logic       ser_en;
  logic [7:0] ser_pdata;
  logic       tx_out;
  logic       busy;
  logic       done;

  logic [2:0] ser_cnt;

  int errors = 0;
  int checks = 0;

  uart_tx_controller #(.WIDTH(3)) dut (
    .UART_TX_CLK        (clk),
    .UART_TX_RST_ASYN   (rst_n),
    .UART_TX_P_DATA     (p_data),
    .UART_TX_Data_Valid (data_valid),
    .UART_TX_PAR_EN     (par_en),
    .UART_TX_PAR_TYP    (par_typ),
    .UART_TX_Ser_Done   (ser_done),
    .UART_TX_Ser_Data   (ser_data),
    .UART_TX_Ser_En     (ser_en),
    .UART_TX_Ser_PData  (ser_pdata),
    .UART_TX_OUT        (tx_out),
    .UART_TX_Busy       (busy),
    .UART_TX_Done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Serializer: LSB-first counter, shares the reset net.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ser_cnt <= 3'd0;
    else if (ser_en) ser_cnt <= ser_cnt + 3'd1;
  end
  assign ser_data = ser_pdata[ser_cnt];
  assign ser_done = (ser_cnt == 3'd7);

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Request a frame; returns at the negedge where the DUT is in START.
  task automatic request(input logic [7:0] d, input logic pe, input logic pt);
    @(negedge clk);
    p_data = d; par_en = pe; par_typ = pt; data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
  endtask

  // Sample len frame cycles at negedges; optionally change P_DATA at index chg_idx.
  task automatic capture(input int len, input int chg_idx, input logic [7:0] chg_val,
                         output logic [10:0] seq, output int en_cnt,
                         output int busy_cnt, output logic done_ok);
    seq = '0; en_cnt = 0; busy_cnt = 0; done_ok = 1'b1;
    for (int i = 0; i < len; i++) begin
      seq = {seq[9:0], tx_out};
      if (ser_en) en_cnt++;
      if (busy) busy_cnt++;
      if (done !== (i == len - 1)) done_ok = 1'b0;
      if (i == chg_idx) p_data = chg_val;
      @(negedge clk);
    end
  endtask

  logic [10:0] seq;
  int          en_cnt;
  int          busy_cnt;
  logic        done_ok;

  initial begin
    rst_n = 1'b0; p_data = 8'h00; data_valid = 1'b0; par_en = 1'b0; par_typ = 1'b0;

    // Reset held for 5 cycles
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("rst_out",   {15'd0, tx_out}, 16'd1);
      check("rst_busy",  {15'd0, busy},   16'd0);
      check("rst_ser_en",{15'd0, ser_en}, 16'd0);
      check("rst_done",  {15'd0, done},   16'd0);
    end
    check("rst_pdata", {8'd0, ser_pdata}, 16'h0000);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_out", {15'd0, tx_out}, 16'd1);

    // 0xA5, even parity
    request(8'hA5, 1'b1, 1'b0);
    capture(11, -1, 8'h00, seq, en_cnt, busy_cnt, done_ok);
    check("a5_seq",   {5'd0, seq}, {5'd0, 11'b01010010101});
    check("a5_en",    en_cnt[15:0], 16'd8);
    check("a5_busy",  busy_cnt[15:0], 16'd11);
    check("a5_done",  {15'd0, done_ok}, 16'd1);
    check("a5_pdata", {8'd0, ser_pdata}, 16'h00A5);
    check("a5_after_busy", {15'd0, busy}, 16'd0);
    check("a5_after_out",  {15'd0, tx_out}, 16'd1);

    // 0x07, odd parity -> 0
    request(8'h07, 1'b1, 1'b1);
    capture(11, -1, 8'h00, seq, en_cnt, busy_cnt, done_ok);
    check("07_odd_seq",  {5'd0, seq}, {5'd0, 11'b01110000001});
    check("07_odd_done", {15'd0, done_ok}, 16'd1);

    // 0x07, even parity -> 1
    request(8'h07, 1'b1, 1'b0);
    capture(11, -1, 8'h00, seq, en_cnt, busy_cnt, done_ok);
    check("07_even_seq", {5'd0, seq}, {5'd0, 11'b01110000011});

    // 0x3C, no parity: 10-cycle frame
    request(8'h3C, 1'b0, 1'b1);
    capture(10, -1, 8'h00, seq, en_cnt, busy_cnt, done_ok);
    check("3c_seq",  {6'd0, seq[9:0]}, {6'd0, 10'b0001111001});
    check("3c_en",   en_cnt[15:0], 16'd8);
    check("3c_busy", busy_cnt[15:0], 16'd10);
    check("3c_done", {15'd0, done_ok}, 16'd1);
    check("3c_idle_after", {15'd0, busy}, 16'd0);

    // Back-to-back with P_DATA changed during DATA of the 0x00 frame
    @(negedge clk);
    p_data = 8'h00; par_en = 1'b0; data_valid = 1'b1;
    @(negedge clk);
    capture(10, 4, 8'hFF, seq, en_cnt, busy_cnt, done_ok);
    check("b2b_first_seq", {6'd0, seq[9:0]}, {6'd0, 10'b0000000001});
    check("b2b_first_done", {15'd0, done_ok}, 16'd1);
    check("b2b_gap_busy", {15'd0, busy}, 16'd0);
    check("b2b_gap_out",  {15'd0, tx_out}, 16'd1);
    @(negedge clk);
    check("b2b_second_start_busy", {15'd0, busy}, 16'd1);
    capture(10, -1, 8'h00, seq, en_cnt, busy_cnt, done_ok);
    data_valid = 1'b0;
    check("b2b_second_seq", {6'd0, seq[9:0]}, {6'd0, 10'b0111111111});
    check("b2b_second_done", {15'd0, done_ok}, 16'd1);

    // Reset during DATA bit 4
    @(negedge clk);
    request(8'h5A, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) @(negedge clk);
    check("pre_rst_ser_en", {15'd0, ser_en}, 16'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out",   {15'd0, tx_out}, 16'd1);
    check("midrst_busy",  {15'd0, busy},   16'd0);
    check("midrst_ser_en",{15'd0, ser_en}, 16'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("postrst_busy", {15'd0, busy},   16'd0);
      check("postrst_out",  {15'd0, tx_out}, 16'd1);
    end
    request(8'h5A, 1'b1, 1'b0);
    capture(11, -1, 8'h00, seq, en_cnt, busy_cnt, done_ok);
    check("postrst_seq",  {5'd0, seq}, {5'd0, 11'b00101101001});
    check("postrst_en",   en_cnt[15:0], 16'd8);
    check("postrst_done", {15'd0, done_ok}, 16'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
